// File: rtl/typhoon_pkg.sv
// Shared types for the tile rasterizer pipeline: scheduler FSM states,
// tile coordinates and the default tile edge.
package typhoon_pkg;

  localparam int TILE_DIM_DEFAULT = 8;

  typedef enum logic [2:0] {
    R_IDLE    = 3'd0,
    R_WAIT    = 3'd1,
    R_START   = 3'd2,
    R_RELEASE = 3'd3,
    R_FLUSH   = 3'd4
  } raster_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } tile_coord_t;

endpackage

// File: rtl/tile_walker.sv
// Screen-tile coordinate walker: steps x by tileDim, wraps x into the next
// tile row, and flags the bottom-right tile.
module tile_walker #(
  parameter int tileDim      = 8,
  parameter int screenWidth  = 640,
  parameter int screenHeight = 480
) (
  input  logic       BOARD_CLK,
  input  logic       RESET_N,
  input  logic       advance,
  input  logic       clear,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       last
);

  localparam logic [9:0] STEP   = 10'(tileDim);
  localparam logic [9:0] LAST_X = 10'(screenWidth - tileDim);
  localparam logic [9:0] LAST_Y = 10'(screenHeight - tileDim);

  // Coordinate registers: clear wins over advance.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (clear) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (advance) begin
      if (x == LAST_X) begin
        x <= 10'd0;
        y <= y + STEP;
      end else begin
        x <= x + STEP;
      end
    end else begin
      x <= x;
      y <= y;
    end
  end

  assign last = (x == LAST_X) && (y == LAST_Y);

endmodule

// File: rtl/tile_scheduler.sv
// Frame sequencer for the tile rasterizer with ping-pong colour buffers.
// Build option TILE_SCHED_PERF_EN adds the raster stall-cycle counter.
module tile_scheduler
  import typhoon_pkg::*;
#(
  parameter int tileDim      = TILE_DIM_DEFAULT,
  parameter int screenWidth  = 640,
  parameter int screenHeight = 480
) (
  input  logic        BOARD_CLK,
  input  logic        RESET_N,
  input  logic        frameStart,
  output logic        frameBusy,
  output logic        frameDone,
  output logic        startRasterizing,
  output logic        rasterTileID,
  output logic [9:0]  rasterxOffset,
  output logic [9:0]  rasteryOffset,
  input  logic        doneRasterizing,
  output logic        drainStart,
  output logic        drainTileID,
  output logic [9:0]  drainxOffset,
  output logic [9:0]  drainyOffset,
  input  logic        drainDone,
  output logic [31:0] rasterStallCycles
);

  raster_state_t rasterState_r, rasterStateNext_s;
  drain_state_t  drainState_r, drainStateNext_s;
  logic [1:0]    full_r, fullNext_s;
  tile_coord_t   slot0_r, slot1_r, slot0Next_s, slot1Next_s;
  tile_coord_t   drainCoord_r, drainCoordNext_s;
  logic          frameBusy_r, frameBusyNext_s;
  logic          frameDone_r, frameDoneNext_s;
  logic          startRast_r, startRastNext_s;
  logic          rasterID_r, rasterIDNext_s;
  logic          drainStart_r, drainStartNext_s;
  logic          drainID_r, drainIDNext_s;
  logic          walkerAdvance_s, walkerClear_s, walkerLast_s;
  logic [9:0]    walkerX_s, walkerY_s;
  logic          rasterSet_s, drainClear_s;

  tile_walker #(
    .tileDim      (tileDim),
    .screenWidth  (screenWidth),
    .screenHeight (screenHeight)
  ) walker (
    .BOARD_CLK (BOARD_CLK),
    .RESET_N   (RESET_N),
    .advance   (walkerAdvance_s),
    .clear     (walkerClear_s),
    .x         (walkerX_s),
    .y         (walkerY_s),
    .last      (walkerLast_s)
  );

  // Raster FSM: 4-phase handshake with the rasterizer and frame bookkeeping.
  always_comb begin
    rasterStateNext_s = rasterState_r;
    frameBusyNext_s   = frameBusy_r;
    frameDoneNext_s   = 1'b0;
    startRastNext_s   = startRast_r;
    rasterIDNext_s    = rasterID_r;
    walkerAdvance_s   = 1'b0;
    walkerClear_s     = 1'b0;
    rasterSet_s       = 1'b0;
    case (rasterState_r)
      R_IDLE: begin
        if (frameStart) begin
          rasterStateNext_s = R_WAIT;
          frameBusyNext_s   = 1'b1;
        end else begin
          rasterStateNext_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (!full_r[rasterID_r]) begin
          rasterStateNext_s = R_START;
          startRastNext_s   = 1'b1;
        end else begin
          rasterStateNext_s = R_WAIT;
        end
      end
      R_START: begin
        if (doneRasterizing) begin
          rasterStateNext_s = R_RELEASE;
          startRastNext_s   = 1'b0;
        end else begin
          rasterStateNext_s = R_START;
        end
      end
      R_RELEASE: begin
        if (!doneRasterizing) begin
          rasterSet_s    = 1'b1;
          rasterIDNext_s = ~rasterID_r;
          if (walkerLast_s) begin
            rasterStateNext_s = R_FLUSH;
          end else begin
            walkerAdvance_s   = 1'b1;
            rasterStateNext_s = R_WAIT;
          end
        end else begin
          rasterStateNext_s = R_RELEASE;
        end
      end
      R_FLUSH: begin
        if ((full_r == 2'b00) && (drainState_r == D_IDLE)) begin
          frameDoneNext_s   = 1'b1;
          frameBusyNext_s   = 1'b0;
          walkerClear_s     = 1'b1;
          rasterIDNext_s    = 1'b0;
          rasterStateNext_s = R_IDLE;
        end else begin
          rasterStateNext_s = R_FLUSH;
        end
      end
      default: begin
        rasterStateNext_s = R_IDLE;
      end
    endcase
  end

  // Drain FSM: one drainStart pulse per full buffer, then wait for drainDone.
  always_comb begin
    drainStateNext_s = drainState_r;
    drainStartNext_s = 1'b0;
    drainIDNext_s    = drainID_r;
    drainCoordNext_s = drainCoord_r;
    drainClear_s     = 1'b0;
    case (drainState_r)
      D_IDLE: begin
        if (full_r[drainID_r]) begin
          drainStartNext_s = 1'b1;
          drainCoordNext_s = drainID_r ? slot1_r : slot0_r;
          drainStateNext_s = D_BUSY;
        end else begin
          drainStateNext_s = D_IDLE;
        end
      end
      D_BUSY: begin
        if (drainDone) begin
          drainClear_s     = 1'b1;
          drainIDNext_s    = ~drainID_r;
          drainStateNext_s = D_IDLE;
        end else begin
          drainStateNext_s = D_BUSY;
        end
      end
      default: begin
        drainStateNext_s = D_IDLE;
      end
    endcase
  end

  // Buffer-full flags and offset slots; a clear and a set never target the same buffer.
  always_comb begin
    fullNext_s  = full_r;
    slot0Next_s = slot0_r;
    slot1Next_s = slot1_r;
    if (drainClear_s) begin
      fullNext_s[drainID_r] = 1'b0;
    end else begin
      fullNext_s = fullNext_s;
    end
    if (rasterSet_s) begin
      fullNext_s[rasterID_r] = 1'b1;
      if (rasterID_r) begin
        slot1Next_s = '{x: walkerX_s, y: walkerY_s};
      end else begin
        slot0Next_s = '{x: walkerX_s, y: walkerY_s};
      end
    end else begin
      fullNext_s = fullNext_s;
    end
  end

  // State and output registers.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rasterState_r <= R_IDLE;
      drainState_r  <= D_IDLE;
      full_r        <= 2'b00;
      slot0_r       <= '{x: 10'd0, y: 10'd0};
      slot1_r       <= '{x: 10'd0, y: 10'd0};
      drainCoord_r  <= '{x: 10'd0, y: 10'd0};
      frameBusy_r   <= 1'b0;
      frameDone_r   <= 1'b0;
      startRast_r   <= 1'b0;
      rasterID_r    <= 1'b0;
      drainStart_r  <= 1'b0;
      drainID_r     <= 1'b0;
    end else begin
      rasterState_r <= rasterStateNext_s;
      drainState_r  <= drainStateNext_s;
      full_r        <= fullNext_s;
      slot0_r       <= slot0Next_s;
      slot1_r       <= slot1Next_s;
      drainCoord_r  <= drainCoordNext_s;
      frameBusy_r   <= frameBusyNext_s;
      frameDone_r   <= frameDoneNext_s;
      startRast_r   <= startRastNext_s;
      rasterID_r    <= rasterIDNext_s;
      drainStart_r  <= drainStartNext_s;
      drainID_r     <= drainIDNext_s;
    end
  end

  assign frameBusy        = frameBusy_r;
  assign frameDone        = frameDone_r;
  assign startRasterizing = startRast_r;
  assign rasterTileID     = rasterID_r;
  assign rasterxOffset    = walkerX_s;
  assign rasteryOffset    = walkerY_s;
  assign drainStart       = drainStart_r;
  assign drainTileID      = drainID_r;
  assign drainxOffset     = drainCoord_r.x;
  assign drainyOffset     = drainCoord_r.y;

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] stallCount_r;
  logic        stallInc_s, stallClear_s;

  assign stallClear_s = (rasterState_r == R_IDLE) && frameStart;
  assign stallInc_s   = (rasterState_r == R_WAIT) && full_r[rasterID_r];

  // Saturating count of cycles the rasterizer waits for a free buffer.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stallCount_r <= 32'd0;
    end else if (stallClear_s) begin
      stallCount_r <= 32'd0;
    end else if (stallInc_s && (stallCount_r != 32'hFFFF_FFFF)) begin
      stallCount_r <= stallCount_r + 32'd1;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end

  assign rasterStallCycles = stallCount_r;
`else
  assign rasterStallCycles = 32'd0;
`endif

endmodule
